// File: rtl/iob_mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, beat counter
// width and the index width helper used for rr_ptr/owner.
package iob_mem_arb_pkg;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Wide enough for MAX_BURST up to 15.
    localparam int BEAT_W = 4;

    function automatic int idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iob_2p_mem.sv
// Simple two-port RAM: one synchronous write port, one registered read port.
// Contents are never cleared.
module iob_2p_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              w_en,
    input  logic              w_port_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              r_port_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (w_en && w_port_en) begin
            mem_q[w_addr] <= data_in;
        end
        if (r_port_en) begin
            data_out <= mem_q[r_addr];
        end
    end

endmodule

// File: rtl/iob_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester at or
// above ptr, wrapping modulo N_REQ.
module iob_rr_pick
    import iob_mem_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_2p_mem_arb.sv
// Round-robin access controller sharing one iob_2p_mem between N_REQ requesters,
// with optional locked bursts of up to MAX_BURST beats.
module iob_2p_mem_arb
    import iob_mem_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int N_REQ     = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    input  logic [N_REQ-1:0]        lock,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic                    burst
);

    localparam int IDX_W = idx_w(N_REQ);

    logic [0:0]        state_q,  state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  owner_q,  owner_d;
    logic [BEAT_W-1:0] beat_q,   beat_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]  win;
    logic              mem_wr, mem_rd;
    logic [DATA_W-1:0] mem_dout;

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] x);
        return (int'(x) >= N_REQ - 1) ? '0 : x + IDX_W'(1);
    endfunction

    iob_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        beat_d   = beat_q;
        gnt      = '0;
        win      = '0;

        // No memory access is issued while reset is held.
        if (!rst) begin
            if (state_q == ST_ARB) begin
                gnt = pick_gnt;
            end else begin
                gnt[owner_q] = req[owner_q];
            end
        end

        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                win = IDX_W'(i);
            end
        end

        if (state_q == ST_ARB) begin
            if (|gnt) begin
                if (lock[win] && MAX_BURST > 1) begin
                    state_d = ST_BURST;
                    owner_d = win;
                    beat_d  = BEAT_W'(1);
                end else begin
                    rr_ptr_d = inc_idx(win);
                end
            end
        end else begin
            // A release cycle may still carry the owner's final beat.
            if (!req[owner_q] || !lock[owner_q] ||
                (beat_q + BEAT_W'(1) == BEAT_W'(MAX_BURST))) begin
                state_d  = ST_ARB;
                rr_ptr_d = inc_idx(owner_q);
                beat_d   = '0;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end

        rvalid_d = gnt & ~we;
    end

    assign mem_wr = (|gnt) &&  we[win];
    assign mem_rd = (|gnt) && !we[win];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            beat_q   <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            beat_q   <= beat_d;
            rvalid_q <= rvalid_d;
        end
    end

    iob_2p_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .w_en      (mem_wr),
        .w_port_en (mem_wr),
        .w_addr    (addr[win*ADDR_W +: ADDR_W]),
        .data_in   (wdata[win*DATA_W +: DATA_W]),
        .r_port_en (mem_rd),
        .r_addr    (addr[win*ADDR_W +: ADDR_W]),
        .data_out  (mem_dout)
    );

    assign rvalid = rvalid_q;
    assign rdata  = (|rvalid_q) ? mem_dout : '0;
    assign burst  = (state_q == ST_BURST);

endmodule

// File: tb/tb_iob_2p_mem_arb.sv
// Bench for iob_2p_mem_arb: vector table, directed burst/reset sequences and
// randomized traffic checked against a behavioural model.
module tb_iob_2p_mem_arb;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int N  = 2;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, we, lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            burst;

    logic [AW-1:0] a_in [N];
    logic [DW-1:0] d_in [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = a_in[i];
            wdata[i*DW +: DW] = d_in[i];
        end
    end

    iob_2p_mem_arb #(.DATA_W(DW), .ADDR_W(AW), .N_REQ(N), .MAX_BURST(MB)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .lock   (lock),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .burst  (burst)
    );

    // Behavioural model: who holds the memory, how many beats are left, what
    // read result is due next cycle.
    int            m_next;
    bit            m_locked;
    int            m_holder;
    int            m_left;
    logic [N-1:0]  m_rvalid;
    logic [DW-1:0] m_rdata;
    bit            m_rknown;
    logic [DW-1:0] m_mem [2**AW];
    bit            m_known [2**AW];
    int            m_g;

    logic [N-1:0]  s_gnt, s_rvalid;
    logic [DW-1:0] s_rdata;
    logic          s_burst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner();
        if (rst) return -1;
        if (m_locked) return req[m_holder] ? m_holder : -1;
        for (int k = 0; k < N; k++) begin
            if (req[(m_next + k) % N]) return (m_next + k) % N;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        if (rst) begin
            m_next   = 0;
            m_locked = 0;
            m_left   = 0;
            m_rvalid = '0;
            return;
        end
        m_rvalid = '0;
        if (g >= 0) begin
            if (we[g]) begin
                m_mem[a_in[g]]   = d_in[g];
                m_known[a_in[g]] = 1;
            end else begin
                m_rvalid = N'(1) << g;
                m_rdata  = m_mem[a_in[g]];
                m_rknown = m_known[a_in[g]];
            end
        end
        if (m_locked) begin
            if (g < 0 || !lock[m_holder] || m_left == 1) begin
                m_locked = 0;
                m_next   = (m_holder + 1) % N;
            end else begin
                m_left--;
            end
        end else if (g >= 0) begin
            if (lock[g] && MB > 1) begin
                m_locked = 1;
                m_holder = g;
                m_left   = MB - 1;
            end else begin
                m_next = (g + 1) % N;
            end
        end
    endtask

    // Inputs are driven 1 time unit after posedge; sample at the negedge.
    task automatic half_check();
        logic [N-1:0] eg;
        #4;
        m_g = model_winner();
        eg  = (m_g >= 0) ? (N'(1) << m_g) : '0;
        s_gnt = gnt; s_rvalid = rvalid; s_rdata = rdata; s_burst = burst;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rvalid", 32'(rvalid), 32'(m_rvalid));
        chk("burst", 32'(burst), 32'(m_locked));
        if (m_rvalid == '0) chk("rdata_idle", 32'(rdata), 32'd0);
        else if (m_rknown)  chk("rdata", 32'(rdata), 32'(m_rdata));
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update(m_g);
        #1;
    endtask

    task automatic cycle();
        half_check();
        edge_step();
    endtask

    task automatic drive(input int i, input logic r, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = r; we[i] = w; lock[i] = l; a_in[i] = a; d_in[i] = d;
    endtask

    task automatic idle();
        req = '0; we = '0; lock = '0;
    endtask

    task automatic reset_cycle();
        rst = 1'b1; idle(); cycle(); rst = 1'b0;
    endtask

    typedef struct {
        logic          rst;
        logic [N-1:0]  req, we, lock;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [N-1:0]  e_gnt, e_rvalid;
        logic [DW-1:0] e_rdata;
        logic          e_burst;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int exp_g [5];
        int exp_b [5];
        int left1;
        bit pend0;
        bit pend [N];

        tbl[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 2'b01, 2'b01, 2'b00, 6'd3, 6'd0, 8'hA5, 8'h00, 2'b01, 2'b00, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 2'b01, 2'b00, 2'b00, 6'd3, 6'd0, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 2'b00, 2'b01, 8'hA5, 1'b0};
        tbl[5]  = '{1'b0, 2'b10, 2'b10, 2'b00, 6'd0, 6'd5, 8'h00, 8'h3C, 2'b10, 2'b00, 8'h00, 1'b0};
        tbl[6]  = '{1'b0, 2'b01, 2'b01, 2'b00, 6'd6, 6'd0, 8'h77, 8'h00, 2'b01, 2'b00, 8'h00, 1'b0};
        tbl[7]  = '{1'b0, 2'b11, 2'b00, 2'b00, 6'd6, 6'd5, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 2'b11, 2'b00, 2'b00, 6'd6, 6'd5, 8'h00, 8'h00, 2'b01, 2'b10, 8'h3C, 1'b0};
        tbl[9]  = '{1'b0, 2'b11, 2'b00, 2'b00, 6'd6, 6'd5, 8'h00, 8'h00, 2'b10, 2'b01, 8'h77, 1'b0};
        tbl[10] = '{1'b0, 2'b11, 2'b00, 2'b00, 6'd6, 6'd5, 8'h00, 8'h00, 2'b01, 2'b10, 8'h3C, 1'b0};
        tbl[11] = '{1'b0, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 2'b00, 2'b01, 8'h77, 1'b0};

        for (int i = 0; i < 2**AW; i++) m_known[i] = 0;
        m_next = 0; m_locked = 0; m_holder = 0; m_left = 0;
        m_rvalid = '0; m_rdata = '0; m_rknown = 0; m_g = -1;
        for (int i = 0; i < N; i++) begin a_in[i] = '0; d_in[i] = '0; end

        // Bring the DUT out of its unknown power-up state before checking.
        rst = 1'b1; idle();
        @(posedge clk); #1;

        for (int v = 0; v < 12; v++) begin
            rst = tbl[v].rst; req = tbl[v].req; we = tbl[v].we; lock = tbl[v].lock;
            a_in[0] = tbl[v].a0; a_in[1] = tbl[v].a1;
            d_in[0] = tbl[v].d0; d_in[1] = tbl[v].d1;
            half_check();
            chk($sformatf("tbl%0d_gnt", v), 32'(s_gnt), 32'(tbl[v].e_gnt));
            chk($sformatf("tbl%0d_rvalid", v), 32'(s_rvalid), 32'(tbl[v].e_rvalid));
            chk($sformatf("tbl%0d_rdata", v), 32'(s_rdata), 32'(tbl[v].e_rdata));
            chk($sformatf("tbl%0d_burst", v), 32'(s_burst), 32'(tbl[v].e_burst));
            edge_step();
        end
        rst = 1'b0;

        // Fill every word so later reads have known contents.
        idle();
        for (int a = 0; a < 2**AW; a++) begin
            drive(0, 1'b1, 1'b1, 1'b0, AW'(a), DW'($urandom_range(0, 255)));
            cycle();
        end
        idle(); cycle();

        // Locked write burst from R1 while R0 waits with a read.
        reset_cycle();
        exp_g = '{2, 2, 2, 2, 1};
        exp_b = '{0, 1, 1, 1, 0};
        left1 = 6;
        pend0 = 0;
        for (int c = 0; c < 16; c++) begin
            if (c == 1) pend0 = 1;
            drive(1, left1 > 0, 1'b1, 1'b1, AW'(40 + left1), DW'($urandom_range(0, 255)));
            drive(0, pend0, 1'b0, 1'b0, 6'd3, 8'h00);
            half_check();
            if (c < 5) begin
                chk($sformatf("lockburst_gnt%0d", c), 32'(s_gnt), 32'(exp_g[c]));
                chk($sformatf("lockburst_burst%0d", c), 32'(s_burst), 32'(exp_b[c]));
            end
            if (s_gnt[1]) left1--;
            if (s_gnt[0]) pend0 = 0;
            edge_step();
        end
        chk("lockburst_all_writes_done", 32'(left1), 32'd0);
        chk("lockburst_read_done", 32'(pend0), 32'd0);
        idle(); cycle();

        // Owner drops lock on its second beat; R1 follows straight away.
        reset_cycle();
        drive(0, 1'b1, 1'b0, 1'b1, 6'd1, 8'h00);
        drive(1, 1'b1, 1'b0, 1'b0, 6'd2, 8'h00);
        half_check(); chk("early_beat1", 32'(s_gnt), 32'h1); edge_step();
        lock[0] = 1'b0;
        half_check(); chk("early_beat2", 32'(s_gnt), 32'h1); edge_step();
        req[0] = 1'b0;
        half_check(); chk("early_r1", 32'(s_gnt), 32'h2);
        chk("early_burst_off", 32'(s_burst), 32'h0); edge_step();
        idle(); cycle();

        // Reset in the middle of a locked read burst.
        reset_cycle();
        drive(0, 1'b1, 1'b0, 1'b1, 6'd7, 8'h00);
        drive(1, 1'b1, 1'b0, 1'b1, 6'd8, 8'h00);
        half_check(); chk("rstmid_beat1", 32'(s_gnt), 32'h1); edge_step();
        rst = 1'b1;
        cycle();
        rst = 1'b0; lock = '0;
        half_check();
        chk("rstmid_gnt", 32'(s_gnt), 32'h1);
        chk("rstmid_burst", 32'(s_burst), 32'h0);
        chk("rstmid_rvalid", 32'(s_rvalid), 32'h0);
        edge_step();
        idle(); cycle();

        // Random traffic: each requester holds its request until granted.
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 6) begin
                    pend[i] = 1;
                    drive(i, 1'b1, 1'($urandom_range(0, 1)), 1'b0,
                          AW'($urandom_range(0, 2**AW - 1)), DW'($urandom_range(0, 255)));
                end
                req[i]  = pend[i];
                lock[i] = ($urandom_range(0, 2) != 0);
            end
            half_check();
            if (m_g >= 0) pend[m_g] = 0;
            edge_step();
        end
        rst = 1'b0; idle(); cycle(); cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
